// File: rtl/serpent_decrypt_round_ctrl.sv
// Serpent 32-round decryption controller: owns the bitsliced state and InvLT,
// steers the external inverse S-box datapath and fetches subkeys K32..K0.
module serpent_decrypt_round_ctrl #(
    parameter int unsigned KEY_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_key_req,
    output logic [5:0]   o_key_addr,
    input  logic         i_key_valid,
    input  logic [127:0] i_key_data,
    output logic [2:0]   o_sbox_index,
    output logic [31:0]  o_sbox_word_0,
    output logic [31:0]  o_sbox_word_1,
    output logic [31:0]  o_sbox_word_2,
    output logic [31:0]  o_sbox_word_3,
    input  logic [31:0]  i_sbox_word_0,
    input  logic [31:0]  i_sbox_word_1,
    input  logic [31:0]  i_sbox_word_2,
    input  logic [31:0]  i_sbox_word_3,
    output logic         o_busy,
    output logic         o_error
);

    localparam int unsigned WAIT_W = (KEY_TIMEOUT < 2) ? 1 : $clog2(KEY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_SBOX,
        ST_LT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [127:0]        s_q, s_d;
    logic [4:0]          round_q, round_d;
    logic [5:0]          key_addr_q, key_addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout;

    function automatic logic [31:0] ror32(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [127:0] inv_lt(input logic [127:0] s);
        logic [31:0] x0, x1, x2, x3;
        x0 = s[31:0];
        x1 = s[63:32];
        x2 = s[95:64];
        x3 = s[127:96];
        x2 = ror32(x2, 22);
        x0 = ror32(x0, 5);
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = x0 ^ x1 ^ x3;
        x3 = ror32(x3, 7);
        x1 = ror32(x1, 1);
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = x1 ^ x0 ^ x2;
        x2 = ror32(x2, 3);
        x0 = ror32(x0, 13);
        return {x3, x2, x1, x0};
    endfunction

    // Fires on the KEY_TIMEOUT-th consecutive wait cycle; a key arriving
    // on that same cycle takes priority.
    assign timeout = (KEY_TIMEOUT != 0) && (state_q == ST_KEY) && !i_key_valid &&
                     (wait_q == WAIT_W'(KEY_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        round_d    = round_q;
        key_addr_d = key_addr_q;
        wait_d     = '0;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_key_req  = 1'b0;
        o_error    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    s_d        = i_data;
                    key_addr_d = 6'd32;
                    round_d    = 5'd31;
                    state_d    = ST_KEY;
                end
            end
            ST_KEY: begin
                o_key_req = 1'b1;
                if (i_key_valid) begin
                    s_d = s_q ^ i_key_data;
                    if (key_addr_q == 6'd32) begin
                        state_d = ST_SBOX;
                    end else if (round_q == 5'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LT;
                    end
                end else if (timeout) begin
                    o_error = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SBOX: begin
                s_d        = {i_sbox_word_3, i_sbox_word_2, i_sbox_word_1, i_sbox_word_0};
                key_addr_d = {1'b0, round_q};
                state_d    = ST_KEY;
            end
            ST_LT: begin
                s_d     = inv_lt(s_q);
                round_d = round_q - 1'b1;
                state_d = ST_SBOX;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            round_q    <= '0;
            key_addr_q <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            round_q    <= round_d;
            key_addr_q <= key_addr_d;
            wait_q     <= wait_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_data        = s_q;
    assign o_key_addr    = key_addr_q;
    assign o_sbox_index  = round_q[2:0];
    assign o_sbox_word_0 = s_q[31:0];
    assign o_sbox_word_1 = s_q[63:32];
    assign o_sbox_word_2 = s_q[95:64];
    assign o_sbox_word_3 = s_q[127:96];

endmodule

// File: tb/tb_serpent_decrypt_round_ctrl.sv
// Bench for serpent_decrypt_round_ctrl: two instances (default and short key
// timeout) driven by a bench-side inverse S-box datapath and key store.
module tb_serpent_decrypt_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic         rst_n[2];
    logic         in_valid[2];
    logic         out_ready[2];
    logic [127:0] in_data[2];
    logic         out_valid[2];
    logic         in_ready[2];
    logic [127:0] out_data[2];
    logic         key_req[2];
    logic [5:0]   key_addr[2];
    logic         key_valid[2];
    logic [127:0] key_data[2];
    logic [2:0]   sidx[2];
    logic [31:0]  sbo0[2], sbo1[2], sbo2[2], sbo3[2];
    logic [31:0]  sbi0[2], sbi1[2], sbi2[2], sbi3[2];
    logic         busy[2];
    logic         err[2];

    logic [127:0] ktab[33];

    // Key source / monitor state per instance
    int   kmax[2], kcnt[2], kdel[2], total_wait[2];
    logic stall_en[2];
    int   stall_addr;
    logic held[2];
    logic [5:0] held_addr[2];
    logic prev_err[2], prev_req[2], prev_busy[2];
    logic [2:0] prev_idx[2];
    int   seq[2][64];
    int   seq_n[2];
    int   sseq[2][64];
    int   sseq_n[2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [127:0] inv_s(input logic [127:0] s, input logic [2:0] idx);
        logic [63:0]  tab;
        logic [127:0] r;
        logic [3:0]   n, o;
        case (idx)
            3'd0: tab = 64'h289F74E1C56A0B3D;
            3'd1: tab = 64'h0AD1974B3C6FE285;
            3'd2: tab = 64'h7A85D63021EB4F9C;
            3'd3: tab = 64'h1F842C53D6EB7A90;
            3'd4: tab = 64'h1DF46BC2E79A3805;
            3'd5: tab = 64'h0AC7356BED1492F8;
            3'd6: tab = 64'hB8C27E940635D1AF;
            default: tab = 64'h241A7BC58FE9D603;
        endcase
        r = '0;
        for (int j = 0; j < 32; j++) begin
            n = {s[96+j], s[64+j], s[32+j], s[j]};
            o = tab[4*n +: 4];
            r[j] = o[0];
            r[32+j] = o[1];
            r[64+j] = o[2];
            r[96+j] = o[3];
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_lt(input logic [127:0] s);
        logic [31:0] x[4];
        for (int i = 0; i < 4; i++) x[i] = s[32*i +: 32];
        x[2] = ror(x[2], 22);                x[0] = ror(x[0], 5);
        x[2] = x[2] ^ x[3] ^ (x[1] << 7);    x[0] = x[0] ^ x[1] ^ x[3];
        x[3] = ror(x[3], 7);                 x[1] = ror(x[1], 1);
        x[3] = x[3] ^ x[2] ^ (x[0] << 3);    x[1] = x[1] ^ x[0] ^ x[2];
        x[2] = ror(x[2], 3);                 x[0] = ror(x[0], 13);
        return {x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [127:0] golden(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ ktab[32];
        s = inv_s(s, 3'd7);
        s = s ^ ktab[31];
        for (int r = 30; r >= 0; r--) begin
            s = inv_lt(s);
            s = inv_s(s, 3'(r % 8));
            s = s ^ ktab[r];
        end
        return s;
    endfunction

    // Bench-side combinational inverse S-box datapath
    assign {sbi3[0], sbi2[0], sbi1[0], sbi0[0]} = inv_s({sbo3[0], sbo2[0], sbo1[0], sbo0[0]}, sidx[0]);
    assign {sbi3[1], sbi2[1], sbi1[1], sbi0[1]} = inv_s({sbo3[1], sbo2[1], sbo1[1], sbo0[1]}, sidx[1]);

    serpent_decrypt_round_ctrl #(.KEY_TIMEOUT(255)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
        .i_data(in_data[0]), .o_valid(out_valid[0]), .i_ready(in_ready[0]), .o_data(out_data[0]),
        .o_key_req(key_req[0]), .o_key_addr(key_addr[0]), .i_key_valid(key_valid[0]),
        .i_key_data(key_data[0]), .o_sbox_index(sidx[0]),
        .o_sbox_word_0(sbo0[0]), .o_sbox_word_1(sbo1[0]), .o_sbox_word_2(sbo2[0]), .o_sbox_word_3(sbo3[0]),
        .i_sbox_word_0(sbi0[0]), .i_sbox_word_1(sbi1[0]), .i_sbox_word_2(sbi2[0]), .i_sbox_word_3(sbi3[0]),
        .o_busy(busy[0]), .o_error(err[0])
    );

    serpent_decrypt_round_ctrl #(.KEY_TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
        .i_data(in_data[1]), .o_valid(out_valid[1]), .i_ready(in_ready[1]), .o_data(out_data[1]),
        .o_key_req(key_req[1]), .o_key_addr(key_addr[1]), .i_key_valid(key_valid[1]),
        .i_key_data(key_data[1]), .o_sbox_index(sidx[1]),
        .o_sbox_word_0(sbo0[1]), .o_sbox_word_1(sbo1[1]), .o_sbox_word_2(sbo2[1]), .o_sbox_word_3(sbo3[1]),
        .i_sbox_word_0(sbi0[1]), .i_sbox_word_1(sbi1[1]), .i_sbox_word_2(sbi2[1]), .i_sbox_word_3(sbi3[1]),
        .o_busy(busy[1]), .o_error(err[1])
    );

    // Key store responder and S-box index monitor, active on the falling edge
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (held[u] && !prev_err[u] && rst_n[u]) begin
                check("key_req_hold", key_req[u], 1'b1);
                check("key_addr_hold", key_addr[u], held_addr[u]);
            end
            if (!key_req[u]) begin
                key_valid[u] = 1'b0;
                kcnt[u] = 0;
                held[u] = 1'b0;
                kdel[u] = (kmax[u] > 0) ? int'($urandom_range(0, kmax[u])) : 0;
            end else if (stall_en[u] && int'(key_addr[u]) == stall_addr) begin
                held[u] = 1'b1;
                held_addr[u] = key_addr[u];
            end else if (kcnt[u] >= kdel[u]) begin
                key_valid[u] = 1'b1;
                key_data[u] = ktab[key_addr[u]];
                total_wait[u] += kdel[u];
                held[u] = 1'b0;
                if (seq_n[u] < 64) begin
                    seq[u][seq_n[u]] = int'(key_addr[u]);
                    seq_n[u]++;
                end
            end else begin
                kcnt[u]++;
                held[u] = 1'b1;
                held_addr[u] = key_addr[u];
            end
            // A KEY cycle entered from a busy non-KEY cycle was preceded by SBOX
            if (key_req[u] && !prev_req[u] && prev_busy[u] && sseq_n[u] < 64) begin
                sseq[u][sseq_n[u]] = int'(prev_idx[u]);
                sseq_n[u]++;
            end
            prev_req[u]  = key_req[u];
            prev_busy[u] = busy[u];
            prev_idx[u]  = sidx[u];
            prev_err[u]  = err[u];
        end
    end

    task automatic run_block(input int u, input logic [127:0] ct, input int hold,
                             output logic [127:0] pt);
        logic [127:0] exp;
        int lat;
        logic got;
        exp = golden(ct);
        seq_n[u] = 0;
        sseq_n[u] = 0;
        total_wait[u] = 0;
        @(negedge clk);
        check("accept_ready", out_ready[u], 1'b1);
        in_data[u] = ct;
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        in_data[u] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        got = 1'b0;
        while (!got && lat < 3000) begin
            if (out_valid[u]) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check("done_reached", got, 1'b1);
        check("latency", lat, 96 + total_wait[u]);
        check("plaintext", out_data[u], exp);
        pt = out_data[u];
        check("addr_trace_len", seq_n[u], 33);
        for (int i = 0; i < 33; i++) check("addr_trace", seq[u][i], 32 - i);
        check("sbox_trace_len", sseq_n[u], 32);
        for (int i = 0; i < 32; i++) check("sbox_trace", sseq[u][i], 7 - (i % 8));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[u] = 1'b1;
            in_data[u] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold_valid_ready", {out_valid[u], out_ready[u]}, 2'b10);
            check("hold_data", out_data[u], exp);
        end
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", {out_valid[u], busy[u], out_ready[u]}, 3'b001);
        @(negedge clk);
        in_ready[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct0, pt0, pt, ct;
        int waits, errs, err_wait;
        logic saw_valid, prev_e, found;

        stall_addr = 20;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; in_valid[u] = 1'b0; in_ready[u] = 1'b0; in_data[u] = '0;
            key_valid[u] = 1'b0; key_data[u] = '0; kmax[u] = 0; kcnt[u] = 0; kdel[u] = 0;
            total_wait[u] = 0; stall_en[u] = 1'b0; held[u] = 1'b0; held_addr[u] = '0;
            prev_err[u] = 1'b0; prev_req[u] = 1'b0; prev_busy[u] = 1'b0; prev_idx[u] = '0;
            seq_n[u] = 0; sseq_n[u] = 0;
        end
        for (int i = 0; i < 33; i++) ktab[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_flags", {out_ready[u], out_valid[u], key_req[u], busy[u], err[u]}, 5'b10000);
            check("reset_data", out_data[u], 128'd0);
            check("reset_key_addr", key_addr[u], 6'd0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Zero-wait key source
        ct0 = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, ct0, 0, pt0);
        ct = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, ct, 0, pt);

        // Random 0..5 cycle key delays: same plaintext as zero-wait
        kmax[0] = 5;
        for (int k = 0; k < 3; k++) begin
            run_block(0, ct0, 0, pt);
            check("delay_vs_zero_wait", pt, pt0);
        end
        kmax[0] = 0;

        // Downstream stall in DONE with i_valid asserted
        ct = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, ct, 10, pt);

        // Key timeout on the short-timeout instance
        stall_en[1] = 1'b1;
        ct = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_data[1] = ct;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        waits = 0; errs = 0; err_wait = -1; saw_valid = 1'b0; prev_e = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (prev_e) check("timeout_idle", {busy[1], out_ready[1], key_req[1]}, 3'b010);
            if (key_req[1] && key_addr[1] == 6'd20) waits++;
            if (err[1]) begin
                errs++;
                err_wait = waits;
            end
            if (out_valid[1]) saw_valid = 1'b1;
            prev_e = err[1];
            @(posedge clk);
            #1;
        end
        check("timeout_error_count", errs, 1);
        check("timeout_error_wait", err_wait, 4);
        check("timeout_no_valid", saw_valid, 1'b0);
        stall_en[1] = 1'b0;
        ct = {$urandom, $urandom, $urandom, $urandom};
        run_block(1, ct, 0, pt);

        // Reset while in LT at round 12
        ct = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_data[0] = ct;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (key_req[0] && key_addr[0] == 6'd12) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("reached_key12", found, 1'b1);
        @(posedge clk);
        #1;
        check("in_lt", {busy[0], key_req[0]}, 2'b10);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", {busy[0], out_ready[0], key_req[0], out_valid[0]}, 4'b0100);
        rst_n[0] = 1'b1;
        ct = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, ct, 0, pt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
